// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO pointer/status controller for a synchronous-read storage array
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr,
  input  logic                  i_rd,
  input  logic                  i_clr_err,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_w_addr,
  output logic [ADDR_WIDTH-1:0] o_r_addr,
  output logic                  o_rd_valid,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] C_AF    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] C_AE    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // A pop frees a slot on the same edge, so a push into a full FIFO is fine when paired with a pop.
  assign w_push_ok = i_wr & (~r_full | i_rd);
  assign w_pop_ok  = i_rd & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + (ADDR_WIDTH+1)'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      w_count_nxt = r_count - (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_rd_valid     <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == C_DEPTH);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= C_AF);
      r_almost_empty <= (w_count_nxt <= C_AE);
      r_rd_valid     <= w_pop_ok;
      // A fresh error in the same cycle as clr_err keeps the flag set.
      r_overflow     <= (r_overflow & ~i_clr_err) | (i_wr & r_full & ~i_rd);
      r_underflow    <= (r_underflow & ~i_clr_err) | (i_rd & r_empty);
    end
  end

  assign o_wr_en        = w_push_ok;
  assign o_w_addr       = r_wr_ptr;
  assign o_r_addr       = r_rd_ptr;
  assign o_rd_valid     = r_rd_valid;
  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_almost_full  = r_almost_full;
  assign o_almost_empty = r_almost_empty;
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - self-checking bench for fifo_ctrl
module tb_fifo_ctrl;

  localparam int AW = 2;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic          clk;
  logic          reset;
  logic          i_wr;
  logic          i_rd;
  logic          i_clr_err;
  logic          o_wr_en;
  logic [AW-1:0] o_w_addr;
  logic [AW-1:0] o_r_addr;
  logic          o_rd_valid;
  logic          o_full;
  logic          o_empty;
  logic          o_almost_full;
  logic          o_almost_empty;
  logic [AW:0]   o_count;
  logic          o_overflow;
  logic          o_underflow;

  fifo_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_wr           (i_wr),
    .i_rd           (i_rd),
    .i_clr_err      (i_clr_err),
    .o_wr_en        (o_wr_en),
    .o_w_addr       (o_w_addr),
    .o_r_addr       (o_r_addr),
    .o_rd_valid     (o_rd_valid),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // {full, empty, almost_full, almost_empty, rd_valid, overflow, underflow}
  function automatic logic [6:0] dut_flags();
    return {o_full, o_empty, o_almost_full, o_almost_empty, o_rd_valid, o_overflow, o_underflow};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic clr);
    @(negedge clk);
    i_wr = wr;
    i_rd = rd;
    i_clr_err = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_wr = 1'b0;
    i_rd = 1'b0;
    i_clr_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic          wr;
    logic          rd;
    logic          clr;
    logic          wr_en;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    int            cnt;
    logic [6:0]    flags;
  } vec_t;

  vec_t vecs[$];

  int           m_cnt;
  int           m_push;
  int           m_pop;
  bit           m_rdv;
  bit           m_ovf;
  bit           m_udf;
  bit           pok;
  bit           popok;
  logic         rwr;
  logic         rrd;
  logic         rclr;
  logic [6:0]   eflags;

  initial begin
    reset = 1'b1;
    i_wr = 1'b0;
    i_rd = 1'b0;
    i_clr_err = 1'b0;

    //            wr rd clr  wr_en wa ra  cnt  flags
    vecs.push_back('{1, 0, 0, 1, 0, 0, 1, 7'b0001000});
    vecs.push_back('{1, 0, 0, 1, 1, 0, 2, 7'b0000000});
    vecs.push_back('{1, 0, 0, 1, 2, 0, 3, 7'b0010000});
    vecs.push_back('{1, 0, 0, 1, 3, 0, 4, 7'b1010000});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 4, 7'b1010010});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 4, 7'b1010010});
    vecs.push_back('{0, 0, 1, 0, 0, 0, 4, 7'b1010000});
    vecs.push_back('{1, 1, 0, 1, 0, 0, 4, 7'b1010100});
    vecs.push_back('{0, 1, 0, 0, 1, 1, 3, 7'b0010100});
    vecs.push_back('{1, 1, 0, 1, 1, 2, 3, 7'b0010100});
    vecs.push_back('{0, 1, 0, 0, 2, 3, 2, 7'b0000100});
    vecs.push_back('{1, 1, 0, 1, 2, 0, 2, 7'b0000100});
    vecs.push_back('{0, 1, 0, 0, 3, 1, 1, 7'b0001100});
    vecs.push_back('{0, 1, 0, 0, 3, 2, 0, 7'b0101100});
    vecs.push_back('{0, 1, 0, 0, 3, 3, 0, 7'b0101001});
    vecs.push_back('{1, 1, 1, 1, 3, 3, 1, 7'b0001001});
    vecs.push_back('{0, 0, 1, 0, 0, 3, 1, 7'b0001000});
    vecs.push_back('{0, 1, 0, 0, 0, 3, 0, 7'b0101100});

    #2;
    chk("async_reset_count", int'(o_count), 0);
    chk("async_reset_flags", int'(dut_flags()), int'(7'b0101000));
    do_reset();
    chk("reset_addrs", int'({o_w_addr, o_r_addr}), 0);
    chk("reset_flags", int'(dut_flags()), int'(7'b0101000));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].clr);
      chk($sformatf("vec%0d_wr_en", i), int'(o_wr_en), int'(vecs[i].wr_en));
      chk($sformatf("vec%0d_w_addr", i), int'(o_w_addr), int'(vecs[i].waddr));
      chk($sformatf("vec%0d_r_addr", i), int'(o_r_addr), int'(vecs[i].raddr));
      tick();
      chk($sformatf("vec%0d_count", i), int'(o_count), vecs[i].cnt);
      chk($sformatf("vec%0d_flags", i), int'(dut_flags()), int'(vecs[i].flags));
    end

    // Asynchronous reset mid-burst at count 3 with a sticky underflow pending.
    do_reset();
    drive(0, 1, 0);
    tick();
    chk("pre_reset_underflow", int'(o_underflow), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      tick();
    end
    chk("pre_reset_count", int'(o_count), 3);
    @(negedge clk);
    i_wr = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_count", int'(o_count), 0);
    chk("midreset_flags", int'(dut_flags()), int'(7'b0101000));
    chk("midreset_addrs", int'({o_w_addr, o_r_addr}), 0);
    #1;
    reset = 1'b0;
    drive(1, 0, 0);
    chk("post_reset_w_addr", int'(o_w_addr), 0);
    chk("post_reset_wr_en", int'(o_wr_en), 1);
    tick();
    chk("post_reset_count", int'(o_count), 1);

    // Random traffic against an occupancy/ticket model.
    do_reset();
    m_cnt = 0; m_push = 0; m_pop = 0; m_rdv = 0; m_ovf = 0; m_udf = 0;
    for (int i = 0; i < 400; i++) begin
      if ((i / 50) % 2 == 0) begin
        rwr = ($urandom_range(0, 99) < 70);
        rrd = ($urandom_range(0, 99) < 35);
      end else begin
        rwr = ($urandom_range(0, 99) < 35);
        rrd = ($urandom_range(0, 99) < 70);
      end
      rclr = ($urandom_range(0, 15) == 0);
      pok   = rwr && (m_cnt < D || rrd);
      popok = rrd && (m_cnt > 0);
      drive(rwr, rrd, rclr);
      chk($sformatf("rnd%0d_wr_en", i), int'(o_wr_en), int'(pok));
      chk($sformatf("rnd%0d_w_addr", i), int'(o_w_addr), m_push % D);
      chk($sformatf("rnd%0d_r_addr", i), int'(o_r_addr), m_pop % D);
      if (rwr && m_cnt == D && !rrd) m_ovf = 1;
      else if (rclr) m_ovf = 0;
      if (rrd && m_cnt == 0) m_udf = 1;
      else if (rclr) m_udf = 0;
      m_cnt  = m_cnt + int'(pok) - int'(popok);
      m_push = m_push + int'(pok);
      m_pop  = m_pop + int'(popok);
      m_rdv  = popok;
      tick();
      eflags = {m_cnt == D, m_cnt == 0, m_cnt >= AF, m_cnt <= AE, m_rdv, m_ovf, m_udf};
      chk($sformatf("rnd%0d_count", i), int'(o_count), m_cnt);
      chk($sformatf("rnd%0d_flags", i), int'(dut_flags()), int'(eflags));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
